// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue/writeback stage wrapped around an external combinational ALU.
//   Each cycle it decodes one instruction and reads a 16x32 register file,
//   forwarding the in-flight result where needed. It then drives the ALU
//   operand bus from a single Ex pipeline register. On the next edge it
//   commits the ALU Result to the register file and New_Flag to the NZCV
//   flag register. The condition code is evaluated here, so instructions
//   that fail their condition retire without side effects.
//
// Ports
//   Clk, Rst            : rising-edge clock, asynchronous active-high reset
//   In_Valid/In_Ready   : instruction handshake; In_Ready = ~Hold
//   Instr               : Cond[31:28] OpCode[27:24] S[23] I[22] Rd[21:18]
//                         Rn[17:14] Rm[13:10] / Imm[13:0]
//   Hold                : freezes Ex register, register file and flags
//   Reg1, Reg2, IV,
//   OpCode, Cond, S     : ALU operand bus (registered)
//   Flag                : current flag register {N,Z,C,V}
//   Result, New_Flag    : ALU outputs, combinational from the operand bus
//   Retire_*            : one-cycle retire pulse with destination, data and
//                         condition outcome
//   Dbg_Addr/Dbg_Data   : combinational architectural register read
//
// Handshake: an instruction transfers on a rising edge where
// In_Valid & In_Ready are both high. With In_Ready low, Instr is ignored
// and the producer must keep it stable until it is accepted.
module alu_issue_stage #(
  parameter int NREG  = 16,
  parameter int IMM_W = 14
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [31:0]        Instr,
  input  logic               Hold,
  output logic signed [31:0] Reg1,
  output logic signed [31:0] Reg2,
  output logic [15:0]        IV,
  output logic [3:0]         OpCode,
  output logic [3:0]         Cond,
  output logic               S,
  output logic [3:0]         Flag,
  input  logic [31:0]        Result,
  input  logic [3:0]         New_Flag,
  output logic               Retire_Valid,
  output logic [3:0]         Retire_Rd,
  output logic [31:0]        Retire_Data,
  output logic               Retire_Pass,
  input  logic [3:0]         Dbg_Addr,
  output logic [31:0]        Dbg_Data
);

  // Architectural state
  logic [31:0] rf [NREG];
  logic [3:0]  flag_q;

  // Ex pipeline register
  logic        ex_valid;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [15:0] ex_iv;
  logic [3:0]  ex_op;
  logic [3:0]  ex_cond;
  logic        ex_s;
  logic [3:0]  ex_rd;

  // Decode fields
  logic [3:0]       d_cond;
  logic [3:0]       d_op;
  logic             d_s;
  logic             d_i;
  logic [3:0]       d_rd;
  logic [3:0]       d_rn;
  logic [3:0]       d_rm;
  logic [IMM_W-1:0] d_imm;

  assign d_cond = Instr[31:28];
  assign d_op   = Instr[27:24];
  assign d_s    = Instr[23];
  assign d_i    = Instr[22];
  assign d_rd   = Instr[21:18];
  assign d_rn   = Instr[17:14];
  assign d_rm   = Instr[13:10];
  assign d_imm  = Instr[IMM_W-1:0];

  // Condition check of the Ex instruction against the committed flags.
  // The predecessor has already committed its flags by the time this
  // instruction sits in Ex, so no flag forwarding is required.
  logic cond_pass;
  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flag_q;

  always_comb begin
    cond_pass = 1'b0;
    case (ex_cond)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc && !fz;
      4'h9: cond_pass = !fc || fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz && (fn == fv);
      4'hD: cond_pass = fz || (fn != fv);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Forwarding: only a result that will actually be written is bypassed.
  logic        fwd_en;
  logic [31:0] rn_val;
  logic [31:0] rm_val;
  assign fwd_en = ex_valid && cond_pass;
  assign rn_val = (fwd_en && (ex_rd == d_rn)) ? Result : rf[d_rn];
  assign rm_val = (fwd_en && (ex_rd == d_rm)) ? Result : rf[d_rm];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < NREG; k++) rf[k] <= '0;
      flag_q       <= '0;
      ex_valid     <= 1'b0;
      ex_reg1      <= '0;
      ex_reg2      <= '0;
      ex_iv        <= '0;
      ex_op        <= '0;
      ex_cond      <= '0;
      ex_s         <= 1'b0;
      ex_rd        <= '0;
      Retire_Valid <= 1'b0;
      Retire_Rd    <= '0;
      Retire_Data  <= '0;
      Retire_Pass  <= 1'b0;
    end else if (Hold) begin
      // Everything frozen; only the retire pulse is suppressed.
      Retire_Valid <= 1'b0;
    end else begin
      // Commit the Ex instruction
      Retire_Valid <= ex_valid;
      Retire_Rd    <= ex_rd;
      Retire_Data  <= Result;
      Retire_Pass  <= ex_valid && cond_pass;
      if (ex_valid && cond_pass) begin
        rf[ex_rd] <= Result;
        if (ex_s) flag_q <= New_Flag;
      end
      // Accept the next instruction
      ex_valid <= In_Valid;
      if (In_Valid) begin
        ex_reg1 <= rn_val;
        ex_reg2 <= d_i ? 32'd0 : rm_val;
        ex_iv   <= d_i ? {{(16-IMM_W){1'b0}}, d_imm} : 16'd0;
        ex_op   <= d_op;
        ex_cond <= d_cond;
        ex_s    <= d_s;
        ex_rd   <= d_rd;
      end
    end
  end

  assign In_Ready = ~Hold;
  assign Reg1     = ex_reg1;
  assign Reg2     = ex_reg2;
  assign IV       = ex_iv;
  assign OpCode   = ex_op;
  assign Cond     = ex_cond;
  assign S        = ex_s;
  assign Flag     = flag_q;
  assign Dbg_Data = rf[Dbg_Addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage. A small ALU model closes the loop from the
// operand bus back to Result/New_Flag. An in-order reference model
// (register file + flags) computes each instruction's expected retire
// record when it is accepted, pushes it to exp_q, and a monitor pops and
// compares on every Retire_Valid pulse.
module tb_alu_issue_stage;

  logic               Clk;
  logic               Rst;
  logic               In_Valid;
  logic               In_Ready;
  logic [31:0]        Instr;
  logic               Hold;
  logic signed [31:0] Reg1;
  logic signed [31:0] Reg2;
  logic [15:0]        IV;
  logic [3:0]         OpCode;
  logic [3:0]         Cond;
  logic               S;
  logic [3:0]         Flag;
  logic [31:0]        Result;
  logic [3:0]         New_Flag;
  logic               Retire_Valid;
  logic [3:0]         Retire_Rd;
  logic [31:0]        Retire_Data;
  logic               Retire_Pass;
  logic [3:0]         Dbg_Addr;
  logic [31:0]        Dbg_Data;

  alu_issue_stage dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Instr(Instr), .Hold(Hold), .Reg1(Reg1), .Reg2(Reg2), .IV(IV),
    .OpCode(OpCode), .Cond(Cond), .S(S), .Flag(Flag), .Result(Result),
    .New_Flag(New_Flag), .Retire_Valid(Retire_Valid), .Retire_Rd(Retire_Rd),
    .Retire_Data(Retire_Data), .Retire_Pass(Retire_Pass),
    .Dbg_Addr(Dbg_Addr), .Dbg_Data(Dbg_Data)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- ALU model ----------------
  // op[1:0]: 0 ADD (C = carry out), 1 SUB, 2 AND, 3 XOR. V always 0.
  function automatic logic [35:0] tb_alu(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] sum;
    logic [31:0] res;
    logic        c;
    sum = '0;
    c   = 1'b0;
    case (op[1:0])
      2'd0: begin sum = {1'b0, a} + {1'b0, b}; res = sum[31:0]; c = sum[32]; end
      2'd1: res = a - b;
      2'd2: res = a & b;
      default: res = a ^ b;
    endcase
    return {res[31], (res == 32'd0), c, 1'b0, res};
  endfunction

  always_comb begin
    {New_Flag, Result} = tb_alu(OpCode, Reg1, Reg2 + {16'd0, IV});
  end

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op,
                                     input logic s, input logic i,
                                     input logic [3:0] rd, input logic [3:0] rn,
                                     input logic [13:0] low);
    return {c, op, s, i, rd, rn, low};
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] m_rf [16];
  logic [3:0]  m_flag;
  logic [36:0] exp_q [$];   // {rd, data, pass}
  int          vectors;
  int          miscompares;
  int          retire_cnt;

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_rf[k] = '0;
    m_flag = '0;
    exp_q.delete();
  endtask

  task automatic model_issue(input logic [31:0] ins);
    logic [31:0] a, b;
    logic [35:0] r;
    logic        pass;
    a    = m_rf[ins[17:14]];
    b    = ins[22] ? {18'd0, ins[13:0]} : m_rf[ins[13:10]];
    r    = tb_alu(ins[27:24], a, b);
    pass = cond_ok(ins[31:28], m_flag);
    if (pass) begin
      m_rf[ins[21:18]] = r[31:0];
      if (ins[23]) m_flag = r[35:32];
    end
    exp_q.push_back({ins[21:18], r[31:0], pass});
  endtask

  logic [36:0] got_e;
  always @(negedge Clk) begin
    if (!Rst && Retire_Valid) begin
      retire_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL retire_unexpected rd=%0d data=%h pass=%0b", Retire_Rd, Retire_Data, Retire_Pass);
      end else begin
        got_e = exp_q.pop_front();
        if ({Retire_Rd, Retire_Data, Retire_Pass} !== got_e) begin
          miscompares++;
          $display("FAIL retire got rd=%0d data=%h pass=%0b expected rd=%0d data=%h pass=%0b",
                   Retire_Rd, Retire_Data, Retire_Pass, got_e[36:33], got_e[32:1], got_e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    In_Valid = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    In_Valid = 1'b1;
    Instr    = ins;
    @(posedge Clk);
    model_issue(ins);
    #1;
    In_Valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Dbg_Addr = 4'd0;
    #1;
    vectors++;
    if (Reg1 !== 32'sd0 || Reg2 !== 32'sd0 || IV !== 16'd0 || Flag !== 4'd0 ||
        Retire_Valid !== 1'b0 || In_Ready !== 1'b1 || Dbg_Data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state reg1=%h reg2=%h iv=%h flag=%b rv=%b rdy=%b dbg=%h expected all zero, ready=1",
               Reg1, Reg2, IV, Flag, Retire_Valid, In_Ready, Dbg_Data);
    end
  endtask

  task automatic test_forwarding();
    issue(mk(4'hE, 4'h0, 1'b0, 1'b1, 4'd1, 4'd0, 14'd5));
    issue(mk(4'hE, 4'h0, 1'b0, 1'b1, 4'd2, 4'd1, 14'd7));
    vectors++;
    if (Reg1 !== 32'sd5 || IV !== 16'd7) begin
      miscompares++;
      $display("FAIL fwd_reg1 got reg1=%0d iv=%0d expected reg1=5 iv=7", Reg1, IV);
    end
    idle(2);
    Dbg_Addr = 4'd2;
    #1;
    vectors++;
    if (Dbg_Data !== 32'd12) begin
      miscompares++;
      $display("FAIL fwd_r2 got %0d expected 12", Dbg_Data);
    end
  endtask

  task automatic test_cond();
    // R5 = R1 - 5 = 0, flags Z
    issue(mk(4'hE, 4'h1, 1'b1, 1'b1, 4'd5, 4'd1, 14'd5));
    // EQ: R4 = R1 + 1 = 6
    issue(mk(4'h0, 4'h0, 1'b0, 1'b1, 4'd4, 4'd1, 14'd1));
    idle(2);
    Dbg_Addr = 4'd4;
    #1;
    vectors++;
    if (Dbg_Data !== 32'd6 || Flag !== 4'b0100) begin
      miscompares++;
      $display("FAIL cond_eq got r4=%0d flag=%b expected r4=6 flag=0100", Dbg_Data, Flag);
    end
    issue(mk(4'hE, 4'h1, 1'b1, 1'b1, 4'd5, 4'd1, 14'd5));
    // NE fails: R4 must stay 6
    issue(mk(4'h1, 4'h0, 1'b0, 1'b1, 4'd4, 4'd2, 14'd9));
    idle(2);
    #1;
    vectors++;
    if (Dbg_Data !== 32'd6) begin
      miscompares++;
      $display("FAIL cond_ne got r4=%0d expected 6", Dbg_Data);
    end
  endtask

  task automatic test_cond_never();
    // R0 - 1 = -1 -> ALU flags 1000, but Cond=F never commits
    issue(mk(4'hF, 4'h1, 1'b1, 1'b1, 4'd8, 4'd0, 14'd1));
    idle(2);
    Dbg_Addr = 4'd8;
    #1;
    vectors++;
    if (Flag !== 4'b0100 || Dbg_Data !== 32'd0) begin
      miscompares++;
      $display("FAIL cond_never got flag=%b r8=%h expected flag=0100 r8=0", Flag, Dbg_Data);
    end
  endtask

  task automatic test_no_forward();
    issue(mk(4'hE, 4'h0, 1'b0, 1'b1, 4'd6, 4'd1, 14'd3));   // R6 = 8
    idle(2);
    issue(mk(4'h1, 4'h0, 1'b0, 1'b1, 4'd6, 4'd1, 14'd100)); // NE fails (Z=1)
    issue(mk(4'hE, 4'h0, 1'b0, 1'b0, 4'd7, 4'd6, {4'd6, 10'd0}));
    vectors++;
    if (Reg1 !== 32'sd8 || Reg2 !== 32'sd8) begin
      miscompares++;
      $display("FAIL no_fwd got reg1=%0d reg2=%0d expected 8 8", Reg1, Reg2);
    end
    idle(2);
    Dbg_Addr = 4'd7;
    #1;
    vectors++;
    if (Dbg_Data !== 32'd16) begin
      miscompares++;
      $display("FAIL no_fwd_r7 got %0d expected 16", Dbg_Data);
    end
  endtask

  task automatic test_hold();
    int cnt0;
    idle(2);
    issue(mk(4'hE, 4'h0, 1'b0, 1'b1, 4'd9, 4'd1, 14'd20));  // R9 = 25
    Hold = 1'b1;
    cnt0 = retire_cnt;
    repeat (3) begin
      @(negedge Clk);
      vectors++;
      if (In_Ready !== 1'b0 || Reg1 !== 32'sd5 || Reg2 !== 32'sd0 ||
          IV !== 16'd20 || Flag !== 4'b0100 || Retire_Valid !== 1'b0) begin
        miscompares++;
        $display("FAIL hold got rdy=%b reg1=%0d reg2=%0d iv=%0d flag=%b rv=%b expected 0 5 0 20 0100 0",
                 In_Ready, Reg1, Reg2, IV, Flag, Retire_Valid);
      end
      @(posedge Clk);
    end
    #1;
    Hold = 1'b0;
    idle(3);
    Dbg_Addr = 4'd9;
    #1;
    vectors++;
    if (retire_cnt !== cnt0 + 1 || Dbg_Data !== 32'd25) begin
      miscompares++;
      $display("FAIL hold_release got retires=%0d r9=%0d expected retires=%0d r9=25",
               retire_cnt - cnt0, Dbg_Data, 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic        v, h;
    for (int n = 0; n < 300; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      h   = ($urandom_range(0, 5) == 0);
      ins = mk(($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE,
               4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 14'($urandom_range(0, 16383)));
      In_Valid = v;
      Hold     = h;
      Instr    = ins;
      @(posedge Clk);
      if (v && !h) model_issue(ins);
      #1;
    end
    Hold = 1'b0;
    idle(3);
    for (int k = 0; k < 16; k++) begin
      Dbg_Addr = 4'(k);
      #1;
      vectors++;
      if (Dbg_Data !== m_rf[k]) begin
        miscompares++;
        $display("FAIL random_rf r%0d got %h expected %h", k, Dbg_Data, m_rf[k]);
      end
    end
    vectors++;
    if (Flag !== m_flag || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL random_end got flag=%b pending=%0d expected flag=%b pending=0",
               Flag, exp_q.size(), m_flag);
    end
  endtask

  task automatic test_reset_midstream();
    int cnt0;
    issue(mk(4'hE, 4'h0, 1'b1, 1'b1, 4'd3, 4'd1, 14'd50));
    #2;
    Rst = 1'b1;
    model_reset();
    cnt0 = retire_cnt;
    Dbg_Addr = 4'd1;
    #1;
    vectors++;
    if (Reg1 !== 32'sd0 || Reg2 !== 32'sd0 || IV !== 16'd0 || Flag !== 4'd0 ||
        Retire_Valid !== 1'b0 || Dbg_Data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_async got reg1=%h reg2=%h iv=%h flag=%b rv=%b r1=%h expected all zero",
               Reg1, Reg2, IV, Flag, Retire_Valid, Dbg_Data);
    end
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    idle(2);
    Dbg_Addr = 4'd3;
    #1;
    vectors++;
    if (Dbg_Data !== 32'd0 || Flag !== 4'd0 || retire_cnt !== cnt0) begin
      miscompares++;
      $display("FAIL reset_discard got r3=%h flag=%b retires=%0d expected 0 0000 0",
               Dbg_Data, Flag, retire_cnt - cnt0);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    retire_cnt  = 0;
    model_reset();
    Rst      = 1'b1;
    In_Valid = 1'b0;
    Instr    = '0;
    Hold     = 1'b0;
    Dbg_Addr = '0;
    repeat (2) @(posedge Clk);
    #1;
    test_reset();
    Rst = 1'b0;
    idle(1);
    test_forwarding();
    test_cond();
    test_cond_never();
    test_no_forward();
    test_hold();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
